oled_hexdump: RTL and testbench
===============================

Name: oled_hexdump

Overview:
- Upstream text-frame builder for the 4x16 OLED character display driver.
- Snapshots eight 32-bit debug words (PC, pipeline registers) and converts them to 64 ASCII hex characters in a shadow buffer, one nibble per cycle.
- Commits the frame to the char_data bus only inside the display's safe window, so the display never latches a half-written frame.
- Generates the display's en.

Parameters:
- HEX_LOWER, 0: 1 = digits a-f (0x61-0x66); 0 = A-F (0x41-0x46).
- REFRESH_CYC, 0: 0 = capture only on cap_req; N>0 = additionally auto-capture every N cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- words_in  in  256  debug words; word k at [32k+31:32k]
- cap_req  in  1  one-cycle capture request
- disp_on  in  1  user enable for the display
- disp_fin  in  1  fin from the display driver
- disp_en  out  1  en to the display driver
- cap_busy  out  1  capture/convert/commit in progress
- char_data  out  512  frame to the display; screen position j at [511-8j -: 8]
- frame_cnt  out  8  committed-frame counter

Behaviour:
- Reset (rst=0, async): state IDLE, char_data all 0x20, disp_en=0, cap_busy=0, frame_cnt=0, pending=0, refresh counter=0, valid=0.
- Screen layout: position j = page*16 + column. Word k occupies positions 8k..8k+7, most significant nibble first.
- ASCII mapping: nibble 0-9 -> 0x30-0x39; 10-15 -> 0x41-0x46, or 0x61-0x66 when HEX_LOWER=1.
- Capture trigger: cap_req OR auto-tick.
  - Auto-tick: 32-bit counter increments every cycle; when it equals REFRESH_CYC-1 it wraps to 0 and pulses the tick. No tick when REFRESH_CYC=0.
- FSM states: IDLE, CONVERT, PEND.
  - IDLE: on a trigger (or pending=1), latch words_in into a 256-bit snapshot, clear pending, set nib_idx=0, assert cap_busy, go to CONVERT.
  - CONVERT: each cycle, shadow[nib_idx] <= ascii(snapshot word nib_idx[5:3], nibble 7-nib_idx[2:0]); nib_idx++. Exactly 64 cycles, then PEND.
  - PEND: safe = !disp_en || disp_fin. When safe: char_data <= shadow, frame_cnt++ (wraps 255->0), valid <= 1, cap_busy <= 0, go to IDLE. Otherwise hold in PEND with char_data unchanged.
- Latency: cap_req sampled at edge 0 gives cap_busy=1 from edge 0. With safe=1 throughout, char_data is updated at edge 65.
- Trigger while busy: sets pending (one deep; further triggers merge). A pending capture starts on the first IDLE cycle after the commit and samples words_in at that time.
- Trigger coincident with the commit edge: sets pending; no request is lost.
- disp_en: registered, equals disp_on && valid. It falls the cycle after disp_on drops. Never asserted before the first commit.
- char_data changes only on a commit edge; the shadow buffer is never visible on the output.
- Reset mid-CONVERT or mid-PEND: immediate return to reset values; the partial frame is discarded.

Decomposition:
- Shared include file src/hexdump_def.v: state encodings (`HD_Idle, `HD_Convert, `HD_Pend), ASCII constants (`ASC_0=0x30, `ASC_UA=0x41, `ASC_LA=0x61, `ASC_SP=0x20).
- One combinational sub-module, oled_hex_ascii (4-bit nibble + lower flag -> 8-bit code), instantiated once on the conversion path.

Test Plan:
1. rst=0 for 3 cycles, then release -> char_data=all 0x20, disp_en=0, cap_busy=0, frame_cnt=0. disp_on=1 alone still gives disp_en=0.
2. word0=0x0123ABCD, others 0, disp_on=0, cap_req at edge 0 -> cap_busy high for edges 0..64. At edge 65: char_data[511:448]=30 31 32 33 41 42 43 44, remaining 56 chars 0x30, frame_cnt=1, cap_busy=0.
3. After a valid frame, disp_on=1 and disp_fin=0 held, issue cap_req -> FSM stays in PEND after 64 cycles with char_data unchanged. Pulse disp_fin for 1 cycle -> commit on that edge, frame_cnt=2.
4. cap_req at edge 0, change word0 to 0xFFFFFFFF at cycle 10, second cap_req at cycle 20 -> first frame shows 0x0123ABCD at edge 65. Second capture starts at edge 66, shows FFFFFFFF at edge 131, frame_cnt=2. A third cap_req on edge 65 itself is also queued, not lost.
5. HEX_LOWER=1, word7=0xDEADBEEF, capture -> char_data[63:0]=64 65 61 64 62 65 65 66.
6. REFRESH_CYC=100, no cap_req -> captures start at cycles 99, 199, ... and frame_cnt increments once per 100 cycles. Drive rst=0 at cycle 130 (mid-CONVERT) -> char_data all 0x20 and frame_cnt=0 immediately.

Source files
------------

// File: rtl/oled_hexdump_pkg.sv
// Shared types and constants for the OLED hex-dump frame builder.
// State encodings and ASCII code points used by the converter and the FSM.
package oled_hexdump_pkg;

  typedef enum logic [1:0] {
    HD_IDLE    = 2'd0,
    HD_CONVERT = 2'd1,
    HD_PEND    = 2'd2
  } hd_state_e;

  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_UA = 8'h41;
  localparam logic [7:0] ASC_LA = 8'h61;
  localparam logic [7:0] ASC_SP = 8'h20;

  localparam int NUM_CHARS = 64;

endpackage

// File: rtl/oled_hexdump_hex_ascii.sv
// Combinational nibble-to-ASCII converter: 0-9 map to digits, 10-15 to
// upper- or lower-case letters depending on the lower flag.
module oled_hex_ascii
  import oled_hexdump_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       lower,
  output logic [7:0] code
);

  always_comb begin
    if (nibble < 4'd10) begin
      code = ASC_0 + {4'd0, nibble};
    end else if (lower) begin
      code = ASC_LA + {4'd0, nibble} - 8'd10;
    end else begin
      code = ASC_UA + {4'd0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/oled_hexdump.sv
// Snapshots eight debug words, converts them one nibble per cycle into a
// shadow buffer, and commits the frame to char_data only in the display's safe window.
module oled_hexdump
  import oled_hexdump_pkg::*;
#(
  parameter bit          HEX_LOWER   = 1'b0,
  parameter int unsigned REFRESH_CYC = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] words_in,
  input  logic         cap_req,
  input  logic         disp_on,
  input  logic         disp_fin,
  output logic         disp_en,
  output logic         cap_busy,
  output logic [511:0] char_data,
  output logic [7:0]   frame_cnt
);

  hd_state_e    state_q, state_d;
  logic         pending_q, pending_d;
  logic [5:0]   nib_q, nib_d;
  logic [255:0] snap_q, snap_d;
  logic [511:0] char_q, char_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         en_q, en_d;
  logic [7:0]   shadow_q [NUM_CHARS];
  logic [7:0]   shadow_d [NUM_CHARS];
  logic [511:0] shadow_flat;

  logic         tick;
  logic         trigger;
  logic         safe;
  logic         start;
  logic [7:0]   bit_idx;
  logic [3:0]   cur_nibble;
  logic [7:0]   cur_code;

  generate
    if (REFRESH_CYC == 0) begin : g_no_refresh
      assign tick = 1'b0;
    end else begin : g_refresh
      localparam logic [31:0] REFRESH_LAST = 32'(REFRESH_CYC - 1);
      logic [31:0] refresh_q, refresh_d;

      always_comb begin
        tick      = (refresh_q == REFRESH_LAST);
        refresh_d = tick ? 32'd0 : refresh_q + 32'd1;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          refresh_q <= 32'd0;
        end else begin
          refresh_q <= refresh_d;
        end
      end
    end
  endgenerate

  assign trigger = cap_req | tick;
  assign safe    = !en_q || disp_fin;
  assign start   = trigger || pending_q;

  // Nibble 0 of each word is its most significant nibble.
  assign bit_idx    = {nib_q[5:3], ~nib_q[2:0], 2'b00};
  assign cur_nibble = snap_q[bit_idx +: 4];

  oled_hex_ascii u_ascii (
    .nibble (cur_nibble),
    .lower  (HEX_LOWER),
    .code   (cur_code)
  );

  generate
    for (genvar gi = 0; gi < NUM_CHARS; gi++) begin : g_pack
      assign shadow_flat[511-8*gi -: 8] = shadow_q[gi];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    case (state_q)
      HD_IDLE:    if (start) state_d = HD_CONVERT;
      HD_CONVERT: if (nib_q == 6'd63) state_d = HD_PEND;
      HD_PEND:    if (safe) state_d = HD_IDLE;
      default:    state_d = HD_IDLE;
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    nib_d     = nib_q;
    snap_d    = snap_q;
    char_d    = char_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    en_d      = disp_on && valid_q;
    shadow_d  = shadow_q;
    case (state_q)
      HD_IDLE: begin
        if (start) begin
          snap_d    = words_in;
          pending_d = 1'b0;
          nib_d     = 6'd0;
          busy_d    = 1'b1;
        end
      end
      HD_CONVERT: begin
        shadow_d[nib_q] = cur_code;
        nib_d           = nib_q + 6'd1;
        if (trigger) pending_d = 1'b1;
      end
      HD_PEND: begin
        // A trigger on the commit edge is queued, not dropped.
        if (trigger) pending_d = 1'b1;
        if (safe) begin
          char_d  = shadow_flat;
          cnt_d   = cnt_q + 8'd1;
          valid_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= HD_IDLE;
      pending_q <= 1'b0;
      nib_q     <= 6'd0;
      snap_q    <= '0;
      char_q    <= {NUM_CHARS{ASC_SP}};
      cnt_q     <= 8'd0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      nib_q     <= nib_d;
      snap_q    <= snap_d;
      char_q    <= char_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      en_q      <= en_d;
    end
  end

  // The shadow buffer needs no reset: it only reaches char_data after a full conversion.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  assign disp_en   = en_q;
  assign cap_busy  = busy_q;
  assign char_data = char_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_oled_hexdump.sv
// Self-checking bench for oled_hexdump: three instances cover upper-case,
// lower-case and auto-refresh builds against a behavioural frame model.
module tb_oled_hexdump;

  localparam logic [511:0] SP_FRAME = {64{8'h20}};

  logic         clk = 1'b0;
  logic         rst;
  logic         rst2;
  logic [255:0] words;
  logic         cap_req;
  logic         disp_on;
  logic         disp_fin;
  logic         cap_req2;
  logic         disp_on2;
  logic         disp_fin2;

  logic         en0, busy0, en1, busy1, en2, busy2;
  logic [511:0] cd0, cd1, cd2;
  logic [7:0]   fc0, fc1, fc2;

  int checks = 0;
  int errors = 0;
  logic [511:0] exp_frame;
  int           exp_cnt;

  always #5 clk = ~clk;

  oled_hexdump #(.HEX_LOWER(1'b0), .REFRESH_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .words_in(words), .cap_req(cap_req),
    .disp_on(disp_on), .disp_fin(disp_fin), .disp_en(en0),
    .cap_busy(busy0), .char_data(cd0), .frame_cnt(fc0)
  );

  oled_hexdump #(.HEX_LOWER(1'b1), .REFRESH_CYC(0)) dut1 (
    .clk(clk), .rst(rst), .words_in(words), .cap_req(cap_req),
    .disp_on(disp_on), .disp_fin(disp_fin), .disp_en(en1),
    .cap_busy(busy1), .char_data(cd1), .frame_cnt(fc1)
  );

  oled_hexdump #(.HEX_LOWER(1'b0), .REFRESH_CYC(100)) dut2 (
    .clk(clk), .rst(rst2), .words_in(words), .cap_req(cap_req2),
    .disp_on(disp_on2), .disp_fin(disp_fin2), .disp_en(en2),
    .cap_busy(busy2), .char_data(cd2), .frame_cnt(fc2)
  );

  // Reference: screen position j shows nibble (j%8) (MS first) of word j/8.
  function automatic logic [511:0] frame_of(input logic [255:0] w, input bit lower);
    logic [511:0] f;
    logic [31:0]  word;
    int           nib;
    f = '0;
    for (int j = 0; j < 64; j++) begin
      word = w[32*(j/8) +: 32];
      nib  = int'((word >> (28 - 4*(j%8))) & 32'hF);
      if (nib < 10)   f[511-8*j -: 8] = 8'(48 + nib);
      else if (lower) f[511-8*j -: 8] = 8'(97 + nib - 10);
      else            f[511-8*j -: 8] = 8'(65 + nib - 10);
    end
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_words();
    for (int k = 0; k < 8; k++) words[32*k +: 32] = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b0; rst2 = 1'b0;
    repeat (3) step();
    checks++;
    if (cd0 !== SP_FRAME) begin errors++; $display("FAIL reset_hold char_data got %h want %h", cd0, SP_FRAME); end
    rst = 1'b1;
    step();
    checks++;
    if (cd0 !== SP_FRAME) begin errors++; $display("FAIL reset_char got %h want %h", cd0, SP_FRAME); end
    checks++;
    if (en0 !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", en0); end
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy0); end
    checks++;
    if (fc0 !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", fc0); end
    disp_on = 1'b1;
    repeat (3) step();
    checks++;
    if (en0 !== 1'b0) begin errors++; $display("FAIL en_before_valid got %b want 0", en0); end
    disp_on = 1'b0;
    step();
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [63:0] want_top;
    want_top = 64'h3031323341424344;
    words = '0;
    words[31:0] = 32'h0123ABCD;
    cap_req = 1'b1;
    step();
    cap_req = 1'b0;
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL busy_edge0 got %b want 1", busy0); end
    for (int i = 1; i <= 64; i++) begin
      step();
      checks++;
      if (busy0 !== 1'b1) begin errors++; $display("FAIL busy_edge%0d got %b want 1", i, busy0); end
    end
    checks++;
    if (cd0 !== SP_FRAME) begin errors++; $display("FAIL no_early_commit got %h want %h", cd0, SP_FRAME); end
    step();
    exp_frame = frame_of(words, 1'b0);
    exp_cnt++;
    checks++;
    if (cd0[511:448] !== want_top) begin errors++; $display("FAIL word0_chars got %h want %h", cd0[511:448], want_top); end
    checks++;
    if (cd0 !== exp_frame) begin errors++; $display("FAIL frame_basic got %h want %h", cd0, exp_frame); end
    checks++;
    if (fc0 !== 8'(exp_cnt)) begin errors++; $display("FAIL cnt_basic got %0d want %0d", fc0, exp_cnt); end
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL busy_edge65 got %b want 0", busy0); end
    $display("test_basic frame %0d committed", exp_cnt);

    for (int it = 0; it < 3; it++) begin
      randomize_words();
      cap_req = 1'b1;
      step();
      cap_req = 1'b0;
      repeat (65) step();
      exp_frame = frame_of(words, 1'b0);
      exp_cnt++;
      checks++;
      if (cd0 !== exp_frame) begin errors++; $display("FAIL frame_rand%0d got %h want %h", it, cd0, exp_frame); end
      checks++;
      if (cd1 !== frame_of(words, 1'b1)) begin errors++; $display("FAIL frame_lower%0d got %h want %h", it, cd1, frame_of(words, 1'b1)); end
      checks++;
      if (fc0 !== 8'(exp_cnt)) begin errors++; $display("FAIL cnt_rand%0d got %0d want %0d", it, fc0, exp_cnt); end
      $display("test_basic random frame %0d words %h", exp_cnt, words);
    end
  endtask

  task automatic test_lower();
    logic [63:0] want_lo, want_up;
    want_lo = 64'h6465616462656566;
    want_up = 64'h4445414442454546;
    words = '0;
    words[255:224] = 32'hDEADBEEF;
    cap_req = 1'b1;
    step();
    cap_req = 1'b0;
    repeat (65) step();
    exp_frame = frame_of(words, 1'b0);
    exp_cnt++;
    checks++;
    if (cd1[63:0] !== want_lo) begin errors++; $display("FAIL lower_word7 got %h want %h", cd1[63:0], want_lo); end
    checks++;
    if (cd0[63:0] !== want_up) begin errors++; $display("FAIL upper_word7 got %h want %h", cd0[63:0], want_up); end
    checks++;
    if (fc1 !== 8'(exp_cnt)) begin errors++; $display("FAIL cnt_lower got %0d want %0d", fc1, exp_cnt); end
    $display("test_lower frame %0d", exp_cnt);
  endtask

  task automatic test_pend();
    logic [511:0] old_frame;
    disp_on = 1'b1;
    disp_fin = 1'b0;
    repeat (2) step();
    checks++;
    if (en0 !== 1'b1) begin errors++; $display("FAIL en_after_valid got %b want 1", en0); end
    old_frame = exp_frame;
    randomize_words();
    cap_req = 1'b1;
    step();
    cap_req = 1'b0;
    repeat (80) step();
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL pend_busy got %b want 1", busy0); end
    checks++;
    if (cd0 !== old_frame) begin errors++; $display("FAIL pend_hold got %h want %h", cd0, old_frame); end
    checks++;
    if (fc0 !== 8'(exp_cnt)) begin errors++; $display("FAIL pend_cnt got %0d want %0d", fc0, exp_cnt); end
    disp_fin = 1'b1;
    step();
    disp_fin = 1'b0;
    exp_frame = frame_of(words, 1'b0);
    exp_cnt++;
    checks++;
    if (cd0 !== exp_frame) begin errors++; $display("FAIL fin_commit got %h want %h", cd0, exp_frame); end
    checks++;
    if (fc0 !== 8'(exp_cnt)) begin errors++; $display("FAIL fin_cnt got %0d want %0d", fc0, exp_cnt); end
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL fin_busy got %b want 0", busy0); end
    disp_on = 1'b0;
    step();
    checks++;
    if (en0 !== 1'b0) begin errors++; $display("FAIL en_fall got %b want 0", en0); end
    $display("test_pend frame %0d committed on fin", exp_cnt);
  endtask

  task automatic test_back_to_back();
    logic [255:0] w1, w2, w3;
    randomize_words();
    w1 = words;
    cap_req = 1'b1;
    step();
    cap_req = 1'b0;
    repeat (10) step();
    randomize_words();
    w2 = words;
    repeat (9) step();
    cap_req = 1'b1;
    step();
    cap_req = 1'b0;
    repeat (45) step();
    exp_cnt++;
    checks++;
    if (cd0 !== frame_of(w1, 1'b0)) begin errors++; $display("FAIL b2b_first got %h want %h", cd0, frame_of(w1, 1'b0)); end
    checks++;
    if (fc0 !== 8'(exp_cnt)) begin errors++; $display("FAIL b2b_cnt1 got %0d want %0d", fc0, exp_cnt); end
    step();
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL b2b_restart got %b want 1", busy0); end
    repeat (65) step();
    exp_cnt++;
    checks++;
    if (cd0 !== frame_of(w2, 1'b0)) begin errors++; $display("FAIL b2b_second got %h want %h", cd0, frame_of(w2, 1'b0)); end
    checks++;
    if (fc0 !== 8'(exp_cnt)) begin errors++; $display("FAIL b2b_cnt2 got %0d want %0d", fc0, exp_cnt); end
    step();
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL b2b_merged got %b want 0", busy0); end
    $display("test_back_to_back pending capture frame %0d", exp_cnt);

    // Trigger landing exactly on the commit edge.
    randomize_words();
    w3 = words;
    cap_req = 1'b1;
    step();
    cap_req = 1'b0;
    repeat (64) step();
    cap_req = 1'b1;
    randomize_words();
    step();
    cap_req = 1'b0;
    exp_cnt++;
    checks++;
    if (cd0 !== frame_of(w3, 1'b0)) begin errors++; $display("FAIL edge_first got %h want %h", cd0, frame_of(w3, 1'b0)); end
    step();
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL edge_queued got %b want 1", busy0); end
    repeat (65) step();
    exp_cnt++;
    checks++;
    if (cd0 !== frame_of(words, 1'b0)) begin errors++; $display("FAIL edge_second got %h want %h", cd0, frame_of(words, 1'b0)); end
    checks++;
    if (fc0 !== 8'(exp_cnt)) begin errors++; $display("FAIL edge_cnt got %0d want %0d", fc0, exp_cnt); end
    $display("test_back_to_back commit-edge capture frame %0d", exp_cnt);
  endtask

  task automatic test_refresh();
    randomize_words();
    rst2 = 1'b1;
    repeat (99) step();
    checks++;
    if (busy2 !== 1'b0) begin errors++; $display("FAIL refresh_early got %b want 0", busy2); end
    step();
    checks++;
    if (busy2 !== 1'b1) begin errors++; $display("FAIL refresh_tick99 got %b want 1", busy2); end
    repeat (65) step();
    checks++;
    if (fc2 !== 8'd1) begin errors++; $display("FAIL refresh_cnt1 got %0d want 1", fc2); end
    checks++;
    if (cd2 !== frame_of(words, 1'b0)) begin errors++; $display("FAIL refresh_frame got %h want %h", cd2, frame_of(words, 1'b0)); end
    repeat (35) step();
    checks++;
    if (busy2 !== 1'b1) begin errors++; $display("FAIL refresh_tick199 got %b want 1", busy2); end
    repeat (65) step();
    checks++;
    if (fc2 !== 8'd2) begin errors++; $display("FAIL refresh_cnt2 got %0d want 2", fc2); end
    repeat (66) step();
    checks++;
    if (busy2 !== 1'b1) begin errors++; $display("FAIL refresh_midconv got %b want 1", busy2); end
    rst2 = 1'b0;
    #1;
    checks++;
    if (cd2 !== SP_FRAME) begin errors++; $display("FAIL async_rst_char got %h want %h", cd2, SP_FRAME); end
    checks++;
    if (fc2 !== 8'd0) begin errors++; $display("FAIL async_rst_cnt got %0d want 0", fc2); end
    checks++;
    if (busy2 !== 1'b0) begin errors++; $display("FAIL async_rst_busy got %b want 0", busy2); end
    step();
    $display("test_refresh done");
  endtask

  initial begin
    rst = 1'b0; rst2 = 1'b0;
    words = '0;
    cap_req = 1'b0; disp_on = 1'b0; disp_fin = 1'b0;
    cap_req2 = 1'b0; disp_on2 = 1'b0; disp_fin2 = 1'b0;
    exp_frame = SP_FRAME;
    exp_cnt = 0;
    test_reset();
    test_basic();
    test_lower();
    test_pend();
    test_back_to_back();
    test_refresh();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
